cpu_dbus_bridge: RTL and testbench
==================================

# cpu_dbus_bridge

Data-bus bridge placed directly downstream of the CPU core's data port (`data_en`/`data_wen`/`data_addr`/`data_wdata`/`data_rdata`). It converts the core's single-cycle-style access into a split request/response handshake toward the memory system. It stalls the core until each access completes. It also detects bus errors and response timeouts.

## Interface
- `TIMEOUT`, default 255: maximum cycles spent in REQ+WAIT before the access is aborted with an error (must be ≥ 2).
- `clk` in 1: clock.
- `rst` in 1: reset; synchronous, active-high.
- `cpu_en` in 1: core requests an access this cycle.
- `cpu_wen` in 4: byte write enables; 0 means read.
- `cpu_addr` in 32: byte address.
- `cpu_wdata` in 32: store data, already lane-aligned.
- `cpu_rdata` out 32: registered full read word; valid in the DONE cycle.
- `cpu_stall` out 1: core must hold its MEM stage and keep its request stable.
- `bus_req_valid` out 1: request valid.
- `bus_req_ready` in 1: request accepted.
- `bus_req_we` out 1: write request.
- `bus_req_be` out 4: byte enables.
- `bus_req_addr` out 32: word-aligned address.
- `bus_req_wdata` out 32: write data.
- `bus_rsp_valid` in 1: response valid; exactly one response per accepted request.
- `bus_rsp_data` in 32: read data.
- `bus_rsp_err` in 1: response error, qualified by `bus_rsp_valid`.
- `bus_err` out 1: one-cycle pulse in the DONE cycle of a failed access.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- **IDLE**
  - On `cpu_en`, capture the request into registers and go to REQ.
  - Captured fields: `bus_req_addr` = {`cpu_addr[31:2]`, 2'b00}; `bus_req_we` = |`cpu_wen`.
  - `bus_req_be` = `cpu_wen` for writes, 4'hF for reads.
  - `bus_rsp_valid` is ignored in IDLE; late or stale responses are dropped.
- **REQ**
  - `bus_req_valid`=1 and all `bus_req_*` fields are held stable.
  - When `bus_req_ready`=1, go to WAIT.
- **WAIT**
  - On `bus_rsp_valid`, latch `cpu_rdata` (reads only; writes leave it unchanged) and go to DONE.
  - If `bus_rsp_err`=1, set `cpu_rdata`=0 and flag an error.
- **DONE**
  - `cpu_stall`=0.
  - `bus_err`=1 if an error was flagged.
  - Always go to IDLE next cycle.
- **Stall**
  - `cpu_stall` = (`cpu_en` & state≠DONE) | state∈{REQ, WAIT}.
  - If `cpu_en` drops mid-access (pipeline flush), the access still runs to completion and its result is discarded.
- **Timeout**
  - A counter clears on entry to REQ and increments each cycle in REQ or WAIT.
  - When it reaches `TIMEOUT` with no completion: go to DONE, `cpu_rdata`=0, `bus_err`=1, `bus_req_valid` deasserted.
  - Any later response for that access arrives in IDLE and is ignored.
- **Simultaneous events:** `bus_rsp_valid` on the same cycle the timeout is reached is a completion, not a timeout.

## Timing
- Reset values: state IDLE; `bus_req_valid`=0; `bus_req_we`=0; `bus_req_be`=0; `bus_req_addr`=0; `bus_req_wdata`=0; `cpu_rdata`=0; `bus_err`=0; counter 0; write buffer empty.
- Reset mid-access abandons the access; no request is reissued.
- Zero-wait bus (ready in the first REQ cycle, response in the first WAIT cycle):
  - IDLE→REQ→WAIT→DONE, so a 4-cycle access.
  - `cpu_stall` high in cycles 0–2, low in cycle 3.
- Each bus wait cycle adds one cycle.
- Back-to-back accesses: the next request is sampled in the IDLE cycle immediately after DONE.
- At most one outstanding bus request at any time.

## Configuration
- Macro `DBUS_WRITE_BUFFER_EN`.
- **Defined:** one-entry posted-write buffer.
  - A write in IDLE with the buffer empty is captured into the buffer, and the FSM goes IDLE→DONE: 2 cycles, stall high in cycle 0 only.
  - The buffer drains via REQ/WAIT independently of the core.
  - Any core access while the buffer is occupied stalls until the drain's response is received, then proceeds normally.
  - A drain error or timeout pulses `bus_err` in the first cycle after the drain completes; `cpu_rdata` is unaffected.
- **Undefined:** writes use the normal 4-cycle path; no buffer logic is present.

## Test plan
- **Zero-wait load:** read at 0x0000_1006, ready and response immediate, data 0xDEADBEEF.
  - `bus_req_addr`=0x0000_1004, `bus_req_be`=4'hF.
  - `cpu_stall` high for 3 cycles; `cpu_rdata`=0xDEADBEEF in DONE.
- **Byte store with waits:** `cpu_wen`=4'b0100 at 0x20, ready after 2 cycles, response after 3 more.
  - `bus_req_be`=4'b0100, `bus_req_we`=1.
  - Stall lasts 8 cycles; `cpu_rdata` unchanged.
- **Error response:** load returns `bus_rsp_err`=1 with data 0x1234.
  - `cpu_rdata`=0, `bus_err` pulses 1 cycle in DONE.
- **Timeout:** `TIMEOUT`=4, ready never asserted.
  - DONE after 4 cycles in REQ, `bus_err`=1.
  - A response injected later in IDLE is ignored and does not change `cpu_rdata`.
- **Reset mid-access:** assert `rst` in WAIT.
  - Next cycle all outputs at reset values; a subsequent response is ignored; a new load completes correctly.
- **With `DBUS_WRITE_BUFFER_EN`:** store then immediate load, bus 3-cycle response.
  - Store stall is 1 cycle.
  - Load stalls until the drain completes, then reads the stored word.

Source files
------------

// File: rtl/cpu_dbus_bridge_if.sv
// Split request/response data bus between the bridge (master) and the memory system (slave).
// Request fields are held stable while bus_req_valid is high; one response per accepted request.
interface cpu_dbus_bridge_if;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic        bus_req_we;
    logic [3:0]  bus_req_be;
    logic [31:0] bus_req_addr;
    logic [31:0] bus_req_wdata;
    logic        bus_rsp_valid;
    logic [31:0] bus_rsp_data;
    logic        bus_rsp_err;

    modport master (
        output bus_req_valid, bus_req_we, bus_req_be, bus_req_addr, bus_req_wdata,
        input  bus_req_ready, bus_rsp_valid, bus_rsp_data, bus_rsp_err
    );

    modport slave (
        input  bus_req_valid, bus_req_we, bus_req_be, bus_req_addr, bus_req_wdata,
        output bus_req_ready, bus_rsp_valid, bus_rsp_data, bus_rsp_err
    );
endinterface

// File: rtl/cpu_dbus_bridge.sv
// CPU data-port bridge to a split req/rsp bus with error and timeout detection; DBUS_WRITE_BUFFER_EN adds a posted-write buffer.
// Latency: 4 cycles on a zero-wait bus, +1 per bus wait cycle; posted writes complete in 2.
// Backpressure: cpu_stall holds the core until its access completes; bus_req_valid holds until bus_req_ready.
module cpu_dbus_bridge #(
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_en,
    input  logic [3:0]        cpu_wen,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_stall,
    output logic              bus_err,
    cpu_dbus_bridge_if.master bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] tmo_cnt;
    logic             tmo_hit;
    logic             drain;
    logic             is_wr;
    logic             unused_addr;

    assign tmo_hit     = (tmo_cnt == CNT_W'(TIMEOUT - 1));
    assign is_wr       = |cpu_wen;
    assign unused_addr = ^cpu_addr[1:0];

`ifdef DBUS_WRITE_BUFFER_EN
    // The request registers double as the single buffer entry; wb_vld marks a drain in flight.
    logic wb_vld;
    assign drain = wb_vld;
`else
    assign drain = 1'b0;
`endif

    // A drain runs behind the core's back, so it only stalls a core that is asking for the bus.
    assign cpu_stall = (cpu_en && state != DONE) || ((state == REQ || state == WAIT) && !drain);

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            tmo_cnt           <= '0;
            cpu_rdata         <= '0;
            bus_err           <= 1'b0;
            bus.bus_req_valid <= 1'b0;
            bus.bus_req_we    <= 1'b0;
            bus.bus_req_be    <= 4'h0;
            bus.bus_req_addr  <= '0;
            bus.bus_req_wdata <= '0;
`ifdef DBUS_WRITE_BUFFER_EN
            wb_vld            <= 1'b0;
`endif
        end else begin
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_en) begin
                        bus.bus_req_addr  <= {cpu_addr[31:2], 2'b00};
                        bus.bus_req_we    <= is_wr;
                        bus.bus_req_be    <= is_wr ? cpu_wen : 4'hF;
                        bus.bus_req_wdata <= cpu_wdata;
`ifdef DBUS_WRITE_BUFFER_EN
                        if (is_wr) begin
                            wb_vld <= 1'b1;
                            state  <= DONE;
                        end else begin
                            bus.bus_req_valid <= 1'b1;
                            tmo_cnt           <= '0;
                            state             <= REQ;
                        end
`else
                        bus.bus_req_valid <= 1'b1;
                        tmo_cnt           <= '0;
                        state             <= REQ;
`endif
                    end
                end
                REQ: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (tmo_hit) begin
                        bus.bus_req_valid <= 1'b0;
                        bus_err           <= 1'b1;
                        if (!drain) cpu_rdata <= '0;
                        state <= drain ? IDLE : DONE;
`ifdef DBUS_WRITE_BUFFER_EN
                        wb_vld <= 1'b0;
`endif
                    end else if (bus.bus_req_ready) begin
                        bus.bus_req_valid <= 1'b0;
                        state             <= WAIT;
                    end
                end
                WAIT: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    // A response landing on the timeout cycle still counts as a completion.
                    if (bus.bus_rsp_valid || tmo_hit) begin
                        if (!drain) begin
                            if (!bus.bus_rsp_valid || bus.bus_rsp_err) cpu_rdata <= '0;
                            else if (!bus.bus_req_we)                  cpu_rdata <= bus.bus_rsp_data;
                        end
                        bus_err <= !bus.bus_rsp_valid || bus.bus_rsp_err;
                        state   <= drain ? IDLE : DONE;
`ifdef DBUS_WRITE_BUFFER_EN
                        wb_vld  <= 1'b0;
`endif
                    end
                end
                DONE: begin
`ifdef DBUS_WRITE_BUFFER_EN
                    if (wb_vld) begin
                        bus.bus_req_valid <= 1'b1;
                        tmo_cnt           <= '0;
                        state             <= REQ;
                    end else begin
                        state <= IDLE;
                    end
`else
                    state <= IDLE;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_dbus_bridge.sv
// Scoreboard bench for cpu_dbus_bridge: directed accesses push expected bus requests and core results,
// independent monitors pop and compare them; a second instance with TIMEOUT=4 covers the timeout path.
module tb_cpu_dbus_bridge;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, cpu_en, to_en;
    logic [3:0]  cpu_wen;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, to_rdata;
    logic        cpu_stall, bus_err, to_stall, to_err;

    cpu_dbus_bridge_if bus();
    cpu_dbus_bridge_if bus_to();

    cpu_dbus_bridge dut (
        .clk(clk), .rst(rst), .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .bus_err(bus_err), .bus(bus)
    );

    cpu_dbus_bridge #(.TIMEOUT(4)) u_to (
        .clk(clk), .rst(rst), .cpu_en(to_en), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(to_rdata), .cpu_stall(to_stall), .bus_err(to_err), .bus(bus_to)
    );

    typedef struct { logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata; } req_t;
    typedef struct { logic [31:0] rdata; logic err; } rsp_t;
    typedef struct { int rdy; int rsp; logic [31:0] data; logic err; } cfg_t;
    typedef struct {
        string name; logic [3:0] wen; logic [31:0] addr; logic [31:0] wdata;
        int rdy; int rsp; logic [31:0] rsp_data; logic rsp_err;
        logic [3:0] exp_be; logic [31:0] exp_addr; logic [31:0] exp_rdata; logic exp_err; int exp_stall;
    } vec_t;

    req_t exp_req_q[$];
    rsp_t exp_rsp_q[$];
    rsp_t to_exp_q[$];
    cfg_t cfg_q[$];

    int checks = 0;
    int errors = 0;

`ifdef DBUS_WRITE_BUFFER_EN
    localparam int ST_B = 1, ST_F = 1;
`else
    localparam int ST_B = 8, ST_F = 4;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string p);
        check({p, "_req_valid"}, 32'(bus.bus_req_valid), 32'd0);
        check({p, "_req_we"},    32'(bus.bus_req_we), 32'd0);
        check({p, "_req_be"},    32'(bus.bus_req_be), 32'd0);
        check({p, "_req_addr"},  bus.bus_req_addr, 32'd0);
        check({p, "_req_wdata"}, bus.bus_req_wdata, 32'd0);
        check({p, "_rdata"},     cpu_rdata, 32'd0);
        check({p, "_bus_err"},   32'(bus_err), 32'd0);
        check({p, "_stall"},     32'(cpu_stall), 32'd0);
    endtask

    // Memory-side responder: one config entry per bus request, consumed in issue order.
    initial begin : responder
        cfg_t cur;
        int   rdy_cnt, rsp_cnt;
        bit   busy, phase;
        busy = 0; phase = 0; rdy_cnt = 0; rsp_cnt = 0;
        cur = '{0, 0, 32'h0, 1'b0};
        bus.bus_req_ready = 0; bus.bus_rsp_valid = 0; bus.bus_rsp_data = 0; bus.bus_rsp_err = 0;
        forever begin
            @(posedge clk); #1;
            bus.bus_req_ready = 0; bus.bus_rsp_valid = 0; bus.bus_rsp_data = 0; bus.bus_rsp_err = 0;
            if (phase) begin
                if (rsp_cnt == 0) begin
                    bus.bus_rsp_valid = 1; bus.bus_rsp_data = cur.data; bus.bus_rsp_err = cur.err;
                    phase = 0;
                end else rsp_cnt--;
            end else if (bus.bus_req_valid) begin
                if (!busy && cfg_q.size() != 0) begin
                    cur = cfg_q.pop_front(); busy = 1; rdy_cnt = cur.rdy;
                end
                if (busy) begin
                    if (rdy_cnt == 0) begin
                        bus.bus_req_ready = 1; busy = 0; phase = 1; rsp_cnt = cur.rsp;
                    end else rdy_cnt--;
                end
            end
        end
    end

    always @(negedge clk) begin : mon_req
        req_t e;
        if (!rst && bus.bus_req_valid && bus.bus_req_ready) begin
            if (exp_req_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL req_unexpected: got request addr 0x%08h, required none", bus.bus_req_addr);
            end else begin
                e = exp_req_q.pop_front();
                check("req_we",   32'(bus.bus_req_we), 32'(e.we));
                check("req_be",   32'(bus.bus_req_be), 32'(e.be));
                check("req_addr", bus.bus_req_addr, e.addr);
                if (e.we) check("req_wdata", bus.bus_req_wdata, e.wdata);
            end
        end
    end

    always @(negedge clk) begin : mon_rsp
        rsp_t e;
        if (!rst && cpu_en && !cpu_stall) begin
            if (exp_rsp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rsp_unexpected: got completion rdata 0x%08h, required none", cpu_rdata);
            end else begin
                e = exp_rsp_q.pop_front();
                check("done_rdata",   cpu_rdata, e.rdata);
                check("done_bus_err", 32'(bus_err), 32'(e.err));
            end
        end
    end

    always @(negedge clk) begin : mon_to
        rsp_t e;
        if (!rst && to_en && !to_stall) begin
            if (to_exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL to_unexpected: got completion rdata 0x%08h, required none", to_rdata);
            end else begin
                e = to_exp_q.pop_front();
                check("tmo_rdata",     to_rdata, e.rdata);
                check("tmo_bus_err",   32'(to_err), 32'(e.err));
                check("tmo_req_valid", 32'(bus_to.bus_req_valid), 32'd0);
            end
        end
    end

    task automatic xfer(input vec_t v);
        req_t r;
        cfg_t c;
        rsp_t o;
        int   n;
        r.we = (v.wen != 4'h0); r.be = v.exp_be; r.addr = v.exp_addr; r.wdata = v.wdata;
        exp_req_q.push_back(r);
        c = '{v.rdy, v.rsp, v.rsp_data, v.rsp_err};
        cfg_q.push_back(c);
        o.rdata = v.exp_rdata; o.err = v.exp_err;
        exp_rsp_q.push_back(o);
        @(posedge clk); #1;
        cpu_en = 1; cpu_wen = v.wen; cpu_addr = v.addr; cpu_wdata = v.wdata;
        n = 0;
        @(negedge clk);
        while (cpu_stall && n < 200) begin
            n++;
            @(negedge clk);
        end
        check({v.name, "_stall_cycles"}, n, v.exp_stall);
        @(posedge clk); #1;
        cpu_en = 0; cpu_wen = 0;
        @(negedge clk);
        check({v.name, "_err_clear"}, 32'(bus_err), 32'd0);
    endtask

    task automatic settle();
`ifdef DBUS_WRITE_BUFFER_EN
        repeat (10) @(posedge clk);
`endif
    endtask

    initial begin : stim
        vec_t v;
        req_t r;
        cfg_t c;
        rsp_t o;
        int   n;
        rst = 1; cpu_en = 0; to_en = 0; cpu_wen = 0; cpu_addr = 0; cpu_wdata = 0;
        bus_to.bus_req_ready = 0; bus_to.bus_rsp_valid = 0; bus_to.bus_rsp_data = 0; bus_to.bus_rsp_err = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check_reset("reset");
        check("reset_to_rdata", to_rdata, 32'd0);

        v = '{"load0", 4'h0, 32'h0000_1006, 32'h0, 0, 0, 32'hDEAD_BEEF, 1'b0, 4'hF, 32'h0000_1004, 32'hDEAD_BEEF, 1'b0, 3};
        xfer(v);
        v = '{"store_b", 4'b0100, 32'h0000_0020, 32'h00AB_0000, 2, 3, 32'hFFFF_FFFF, 1'b0, 4'b0100, 32'h0000_0020, 32'hDEAD_BEEF, 1'b0, ST_B};
        xfer(v);
        settle();
        v = '{"load_err", 4'h0, 32'h0000_1010, 32'h0, 1, 1, 32'h0000_1234, 1'b1, 4'hF, 32'h0000_1010, 32'h0, 1'b1, 5};
        xfer(v);
        v = '{"load_w", 4'h0, 32'h0000_2003, 32'h0, 0, 2, 32'hCAFE_F00D, 1'b0, 4'hF, 32'h0000_2000, 32'hCAFE_F00D, 1'b0, 5};
        xfer(v);
        v = '{"store_f", 4'hF, 32'h0000_0044, 32'h1122_3344, 1, 0, 32'h0000_0099, 1'b0, 4'hF, 32'h0000_0044, 32'hCAFE_F00D, 1'b0, ST_F};
        xfer(v);
        settle();

        // Reset while the load sits in WAIT; its response then arrives in IDLE.
        c = '{0, 6, 32'h7777_7777, 1'b0};
        cfg_q.push_back(c);
        r = '{1'b0, 4'hF, 32'h0000_0300, 32'h0};
        exp_req_q.push_back(r);
        @(posedge clk); #1;
        cpu_en = 1; cpu_wen = 0; cpu_addr = 32'h0000_0300;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_wait_stall", 32'(cpu_stall), 32'd1);
        rst = 1; cpu_en = 0;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check_reset("rst_mid");
        repeat (10) @(negedge clk);
        check("rst_stale_rdata", cpu_rdata, 32'd0);
        check("rst_stale_err", 32'(bus_err), 32'd0);
        v = '{"load_post_rst", 4'h0, 32'h0000_0304, 32'h0, 0, 0, 32'h600D_F00D, 1'b0, 4'hF, 32'h0000_0304, 32'h600D_F00D, 1'b0, 3};
        xfer(v);

        // Timeout: ready never arrives on the TIMEOUT=4 instance.
        o = '{32'h0, 1'b1};
        to_exp_q.push_back(o);
        @(posedge clk); #1;
        to_en = 1; cpu_wen = 0; cpu_addr = 32'h0000_0500;
        n = 0;
        @(negedge clk);
        while (to_stall && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("tmo_stall_cycles", n, 5);
        @(posedge clk); #1;
        to_en = 0;
        @(negedge clk);
        check("tmo_err_clear", 32'(to_err), 32'd0);
        @(posedge clk); #1;
        bus_to.bus_rsp_valid = 1; bus_to.bus_rsp_data = 32'hAAAA_5555;
        @(posedge clk); #1;
        bus_to.bus_rsp_valid = 0; bus_to.bus_rsp_data = 0;
        @(negedge clk);
        check("tmo_stale_rdata", to_rdata, 32'd0);
        check("tmo_stale_err", 32'(to_err), 32'd0);

`ifdef DBUS_WRITE_BUFFER_EN
        v = '{"wb_store", 4'hF, 32'h0000_0080, 32'h55AA_1234, 0, 2, 32'h0, 1'b0, 4'hF, 32'h0000_0080, 32'h600D_F00D, 1'b0, 1};
        xfer(v);
        v = '{"wb_load", 4'h0, 32'h0000_0080, 32'h0, 0, 0, 32'h55AA_1234, 1'b0, 4'hF, 32'h0000_0080, 32'h55AA_1234, 1'b0, 6};
        xfer(v);
`endif

        repeat (3) @(negedge clk);
        check("req_q_drained", 32'(exp_req_q.size()), 32'd0);
        check("rsp_q_drained", 32'(exp_rsp_q.size()), 32'd0);
        check("cfg_q_drained", 32'(cfg_q.size()), 32'd0);
        check("to_q_drained",  32'(to_exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
